// File: rtl/foc_mul_arbiter.sv
`default_nettype none
// ============================================================================
// foc_mul_arbiter: round-robin scheduler sharing one pipelined 32x32 multiplier
// Revision: 1.0
// ============================================================================
module foc_mul_arbiter #(
  parameter int N       = 4,
  parameter int MUL_LAT = 2,
  parameter int QSHIFT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [32*N-1:0]     op_a,
  input  logic [32*N-1:0]     op_b,
  output logic [N-1:0]        gnt,
  output logic [31:0]         mul_a,
  output logic [31:0]         mul_b,
  input  logic [63:0]         mul_res,
  output logic [N-1:0]        res_vld,
  output logic [63:0]         res_data,
  output logic [31:0]         res_q,
  output logic                busy
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [63:0] C_QMAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] C_QMIN = 64'shFFFF_FFFF_8000_0000;

  logic [IDXW-1:0]              ptr_q, ptr_d;
  logic [IDXW-1:0]              win_w;
  logic                         grant_w;
  logic [31:0]                  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [MUL_LAT:0]             tag_vld_q, tag_vld_d;
  logic [MUL_LAT:0][IDXW-1:0]   tag_idx_q, tag_idx_d;
  logic [N-1:0]                 res_vld_q, res_vld_d;
  logic [63:0]                  res_data_q, res_data_d;
  logic [31:0]                  res_q_q, res_q_d;
  logic signed [63:0]           shifted_w;

  // Search starts at the round-robin pointer and wraps modulo N
  always_comb begin
    logic [IDXW-1:0] cand;
    int j;
    cand    = '0;
    j       = 0;
    win_w   = '0;
    grant_w = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      cand = IDXW'(j);
      if (!grant_w && req[cand]) begin
        grant_w = 1'b1;
        win_w   = cand;
      end
    end
    if (rst) grant_w = 1'b0;
  end

  always_comb begin
    gnt     = '0;
    ptr_d   = ptr_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    for (int i = 0; i < N; i++) begin
      if (grant_w && (win_w == IDXW'(i))) begin
        gnt[i]  = 1'b1;
        mul_a_d = op_a[32*i +: 32];
        mul_b_d = op_b[32*i +: 32];
      end
    end
    if (grant_w) ptr_d = (win_w == IDXW'(N-1)) ? '0 : win_w + IDXW'(1);
  end

  // Owner tags travel alongside the multiplier so the last stage lines up with mul_res
  always_comb begin
    tag_vld_d    = '0;
    tag_idx_d    = '0;
    tag_vld_d[0] = grant_w;
    tag_idx_d[0] = win_w;
    for (int s = 1; s <= MUL_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
  end

  assign shifted_w = $signed(mul_res) >>> QSHIFT;

  always_comb begin
    res_vld_d  = '0;
    res_data_d = res_data_q;
    res_q_d    = res_q_q;
    if (tag_vld_q[MUL_LAT]) begin
      for (int i = 0; i < N; i++) begin
        res_vld_d[i] = (tag_idx_q[MUL_LAT] == IDXW'(i));
      end
      res_data_d = mul_res;
      if (shifted_w > C_QMAX)      res_q_d = 32'h7FFF_FFFF;
      else if (shifted_w < C_QMIN) res_q_d = 32'h8000_0000;
      else                         res_q_d = shifted_w[31:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      tag_vld_q  <= '0;
      tag_idx_q  <= '0;
      res_vld_q  <= '0;
      res_data_q <= '0;
      res_q_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      tag_vld_q  <= tag_vld_d;
      tag_idx_q  <= tag_idx_d;
      res_vld_q  <= res_vld_d;
      res_data_q <= res_data_d;
      res_q_q    <= res_q_d;
    end
  end

  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign res_vld  = res_vld_q;
  assign res_data = res_data_q;
  assign res_q    = res_q_q;
  assign busy     = (|tag_vld_q) | (|res_vld_q);

endmodule
`default_nettype wire

// File: tb/tb_foc_mul_arbiter.sv
`default_nettype none
// ============================================================================
// tb_foc_mul_arbiter: table-driven bench with a 2-cycle multiplier model
// Revision: 1.0
// ============================================================================
module tb_foc_mul_arbiter;

  localparam int N       = 4;
  localparam int MUL_LAT = 2;
  localparam int QSHIFT  = 15;
  localparam int NROWS   = 23;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [32*N-1:0] op_a, op_b;
  logic [N-1:0]    gnt;
  logic [31:0]     mul_a, mul_b;
  logic [63:0]     mul_res;
  logic [N-1:0]    res_vld;
  logic [63:0]     res_data;
  logic [31:0]     res_q;
  logic            busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  foc_mul_arbiter #(.N(N), .MUL_LAT(MUL_LAT), .QSHIFT(QSHIFT)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .gnt(gnt),
    .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res), .res_vld(res_vld),
    .res_data(res_data), .res_q(res_q), .busy(busy)
  );

  // External multiplier: signed 32x32, two register stages
  logic signed [63:0] ext_a, ext_b;
  logic [63:0]        p1, p2;
  assign ext_a = {{32{mul_a[31]}}, mul_a};
  assign ext_b = {{32{mul_b[31]}}, mul_b};
  always_ff @(posedge clk) begin
    p1 <= ext_a * ext_b;
    p2 <= p1;
  end
  assign mul_res = p2;

  typedef struct packed {
    logic [3:0]   req;
    logic [127:0] a;
    logic [127:0] b;
    logic [3:0]   gnt;
    logic [3:0]   rv;
    logic [63:0]  data;
    logic [31:0]  q;
  } vec_t;

  vec_t tbl [NROWS];

  function automatic vec_t mk(input logic [3:0] rq, input logic [127:0] a, input logic [127:0] b,
                              input logic [3:0] g, input logic [3:0] rv,
                              input logic [63:0] d, input logic [31:0] q);
    vec_t v;
    v.req = rq; v.a = a; v.b = b; v.gnt = g; v.rv = rv; v.data = d; v.q = q;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] ca, cb, z;
    logic         exp_busy;
    z  = '0;
    ca = {32'd4, 32'd3, 32'd2, 32'd1};
    cb = {4{32'h0001_0000}};

    // Contention, pointer wrap, Q scaling/saturation, dropped request, single request
    tbl[0]  = mk(4'hF, ca, cb, 4'b0001, 4'b0000, 64'd0, 32'd0);
    tbl[1]  = mk(4'hF, ca, cb, 4'b0010, 4'b0000, 64'd0, 32'd0);
    tbl[2]  = mk(4'hF, ca, cb, 4'b0100, 4'b0000, 64'd0, 32'd0);
    tbl[3]  = mk(4'hF, ca, cb, 4'b1000, 4'b0000, 64'd0, 32'd0);
    tbl[4]  = mk(4'hF, ca, cb, 4'b0001, 4'b0001, 64'h1_0000, 32'd2);
    tbl[5]  = mk(4'hF, ca, cb, 4'b0010, 4'b0010, 64'h2_0000, 32'd4);
    tbl[6]  = mk(4'hF, ca, cb, 4'b0100, 4'b0100, 64'h3_0000, 32'd6);
    tbl[7]  = mk(4'hF, ca, cb, 4'b1000, 4'b1000, 64'h4_0000, 32'd8);
    tbl[8]  = mk(4'b1001, {32'h7FFF_FFFF, 32'd0, 32'd0, 32'd32768},
                 {32'h7FFF_FFFF, 32'd0, 32'd0, 32'd1234}, 4'b0001, 4'b0001, 64'h1_0000, 32'd2);
    tbl[9]  = mk(4'b1001, {32'h7FFF_FFFF, 32'd0, 32'd0, 32'd32768},
                 {32'h7FFF_FFFF, 32'd0, 32'd0, 32'd1234}, 4'b1000, 4'b0010, 64'h2_0000, 32'd4);
    tbl[10] = mk(4'b0001, {96'd0, 32'h8000_0000}, {96'd0, 32'h7FFF_FFFF},
                 4'b0001, 4'b0100, 64'h3_0000, 32'd6);
    tbl[11] = mk(4'b0110, {32'd0, 32'd9, 32'd5, 32'd0}, {32'd0, 32'd9, 32'hFFFF_FFF9, 32'd0},
                 4'b0010, 4'b1000, 64'h4_0000, 32'd8);
    tbl[12] = mk(4'b0000, z, z, 4'b0000, 4'b0001, 64'h0000_0000_0269_0000, 32'd1234);
    tbl[13] = mk(4'b0000, z, z, 4'b0000, 4'b1000, 64'h3FFF_FFFF_0000_0001, 32'h7FFF_FFFF);
    tbl[14] = mk(4'b0000, z, z, 4'b0000, 4'b0001, 64'hC000_0000_8000_0000, 32'h8000_0000);
    tbl[15] = mk(4'b0000, z, z, 4'b0000, 4'b0010, 64'hFFFF_FFFF_FFFF_FFDD, 32'hFFFF_FFFF);
    tbl[16] = mk(4'b0000, z, z, 4'b0000, 4'b0000, 64'd0, 32'd0);
    tbl[17] = mk(4'b0010, {32'd0, 32'd0, 32'd3, 32'd0}, {32'd0, 32'd0, 32'hFFFF_FFFB, 32'd0},
                 4'b0010, 4'b0000, 64'd0, 32'd0);
    tbl[18] = mk(4'b0000, z, z, 4'b0000, 4'b0000, 64'd0, 32'd0);
    tbl[19] = mk(4'b0000, z, z, 4'b0000, 4'b0000, 64'd0, 32'd0);
    tbl[20] = mk(4'b0000, z, z, 4'b0000, 4'b0000, 64'd0, 32'd0);
    tbl[21] = mk(4'b0000, z, z, 4'b0000, 4'b0010, 64'hFFFF_FFFF_FFFF_FFF1, 32'hFFFF_FFFF);
    tbl[22] = mk(4'b0000, z, z, 4'b0000, 4'b0000, 64'd0, 32'd0);

    // Reset state, with requests pending to prove gnt is forced low
    rst  = 1'b1;
    req  = 4'hF;
    op_a = ca;
    op_b = cb;
    @(negedge clk);
    check("reset gnt", 64'(gnt), 64'd0);
    check("reset res_vld", 64'(res_vld), 64'd0);
    check("reset res_data", res_data, 64'd0);
    check("reset res_q", 64'(res_q), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset mul_a", 64'(mul_a), 64'd0);
    check("reset mul_b", 64'(mul_b), 64'd0);
    next_cycle();
    rst = 1'b0;

    for (int r = 0; r < NROWS; r++) begin
      req  = tbl[r].req;
      op_a = tbl[r].a;
      op_b = tbl[r].b;
      exp_busy = 1'b0;
      for (int k = 1; k <= MUL_LAT + 2; k++) begin
        if (r - k >= 0 && tbl[r-k].gnt != 4'b0000) exp_busy = 1'b1;
      end
      @(negedge clk);
      check($sformatf("row%0d gnt", r), 64'(gnt), 64'(tbl[r].gnt));
      check($sformatf("row%0d res_vld", r), 64'(res_vld), 64'(tbl[r].rv));
      check($sformatf("row%0d busy", r), 64'(busy), 64'(exp_busy));
      if (tbl[r].rv != 4'b0000) begin
        check($sformatf("row%0d res_data", r), res_data, tbl[r].data);
        check($sformatf("row%0d res_q", r), 64'(res_q), 64'(tbl[r].q));
      end
      next_cycle();
    end

    // Reset mid-flight: pointer sits at 2 here, two products issued then rst
    req  = 4'b0011;
    op_a = {32'd0, 32'd0, 32'd13, 32'd11};
    op_b = {32'd0, 32'd0, 32'd13, 32'd11};
    @(negedge clk);
    check("mid c0 gnt", 64'(gnt), 64'b0001);
    next_cycle();
    @(negedge clk);
    check("mid c1 gnt", 64'(gnt), 64'b0010);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("mid rst gnt", 64'(gnt), 64'd0);
    check("mid rst res_vld", 64'(res_vld), 64'd0);
    check("mid rst busy", 64'(busy), 64'd0);
    check("mid rst res_data", res_data, 64'd0);
    check("mid rst res_q", 64'(res_q), 64'd0);
    check("mid rst mul_a", 64'(mul_a), 64'd0);
    next_cycle();
    rst = 1'b0;
    req = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("post rst%0d res_vld", c), 64'(res_vld), 64'd0);
      check($sformatf("post rst%0d busy", c), 64'(busy), 64'd0);
      next_cycle();
    end

    // Pointer back at 0: requester 0 must beat requester 2
    req  = 4'b0101;
    op_a = {32'd0, 32'd100, 32'd0, 32'd6};
    op_b = {32'd0, 32'd100, 32'd0, 32'd7};
    @(negedge clk);
    check("post rst gnt", 64'(gnt), 64'b0001);
    next_cycle();
    req = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 4) begin
        check("post rst res_vld", 64'(res_vld), 64'b0001);
        check("post rst res_data", res_data, 64'd42);
        check("post rst res_q", 64'(res_q), 64'd0);
      end else begin
        check($sformatf("post rst wait%0d res_vld", k), 64'(res_vld), 64'd0);
      end
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
